// File: rtl/vrf_pkg.sv
// Shared types and constants for the vector register file write arbiter.
package vrf_pkg;

  localparam int DEF_WIDTH        = 24;
  localparam int DEF_REGNUM       = 16;
  localparam int DEF_VECTOR_WIDTH = 8;
  localparam int DEF_ADDRESSWIDTH = 4;
  localparam int DEF_TIMEOUT      = 15;
  localparam int DEF_LANE_W       = $clog2(DEF_VECTOR_WIDTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  typedef logic [DEF_LANE_W-1:0]       lane_t;
  typedef logic [DEF_ADDRESSWIDTH-1:0] vreg_addr_t;

  // Register 15 aliases the program counter and must never be written here.
  localparam vreg_addr_t PC_REG = 4'hF;

  // True when the address targets the PC alias.
  function automatic logic is_pc_reg(input vreg_addr_t addr);
    return (addr == PC_REG);
  endfunction

endpackage

// File: rtl/vrf_scoreboard.sv
// Per-register pending-write scoreboard. A set and a clear of the same
// register in the same cycle leave the register busy.
module vrf_scoreboard #(
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    set_en,
  input  logic [ADDRESSWIDTH-1:0] set_addr,
  input  logic                    clr_en,
  input  logic [ADDRESSWIDTH-1:0] clr_addr,
  output logic [REGNUM-1:0]       busy
);

  logic [REGNUM-1:0] busy_r;
  logic [REGNUM-1:0] set_mask_s;
  logic [REGNUM-1:0] clr_mask_s;

  // Decode set/clear requests into one-hot masks.
  always_comb begin
    set_mask_s = '0;
    clr_mask_s = '0;
    if (set_en) begin
      set_mask_s[set_addr] = 1'b1;
    end else begin
      set_mask_s = '0;
    end
    if (clr_en) begin
      clr_mask_s[clr_addr] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
  end

  // Apply clear first, then set, so set wins on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else begin
      busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/vrf_write_arbiter.sv
// Arbitrates the single VRF write port between the vector ALU (V, one beat
// per vector) and the load unit (E, element bursts). Optional statistics
// counters are compiled in when VRF_ARB_STATS_EN is defined.
module vrf_write_arbiter
  import vrf_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int REGNUM       = DEF_REGNUM,
  parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
  parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  localparam int LANE_W      = $clog2(VECTOR_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          v_valid,
  output logic                          v_ready,
  input  logic [ADDRESSWIDTH-1:0]       v_wd,
  input  logic [VECTOR_WIDTH*WIDTH-1:0] v_data,
  input  logic                          e_valid,
  output logic                          e_ready,
  input  logic [ADDRESSWIDTH-1:0]       e_wd,
  input  logic [LANE_W-1:0]             e_idx,
  input  logic [WIDTH-1:0]              e_data,
  input  logic                          e_last,
  output logic                          we,
  output logic [ADDRESSWIDTH-1:0]       wd3,
  output logic                          isvector,
  output logic                          vect_esc,
  output logic [LANE_W-1:0]             index_A,
  output logic [WIDTH-1:0]              data_in,
  output logic [VECTOR_WIDTH*WIDTH-1:0] data_in_v,
  output logic [REGNUM-1:0]             busy,
  output logic                          err
`ifdef VRF_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_v_grants,
  output logic [31:0]                   stat_e_beats,
  output logic [31:0]                   stat_v_stalls
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  arb_state_t              state_r, state_nxt_s;
  logic                    favour_v_r;
  logic [TMO_W-1:0]        tmo_r;
  logic [ADDRESSWIDTH-1:0] lock_reg_r;
  logic                    lock_bad_r;
  logic                    clr_pend_r;

  logic                    v_ready_s, e_ready_s;
  logic                    v_fire_s, e_fire_s, e_first_s;
  logic                    v_bad_s, e_bad_s, tmo_hit_s;
  logic [ADDRESSWIDTH-1:0] e_addr_s;

  logic                    we_r, isvector_r, vect_esc_r, err_r;
  logic [ADDRESSWIDTH-1:0] wd3_r;
  logic [LANE_W-1:0]       index_a_r;
  logic [WIDTH-1:0]        data_in_r;
  logic [VECTOR_WIDTH*WIDTH-1:0] data_in_v_r;

  assign v_fire_s  = v_valid && v_ready_s;
  assign e_fire_s  = e_valid && e_ready_s;
  assign e_first_s = e_fire_s && (state_r == IDLE);
  // Burst beats after the first ignore e_wd and target the locked register.
  assign e_addr_s  = (state_r == IDLE) ? e_wd : lock_reg_r;
  assign v_bad_s   = is_pc_reg(vreg_addr_t'(v_wd));
  assign e_bad_s   = (state_r == IDLE) ? is_pc_reg(vreg_addr_t'(e_wd)) : lock_bad_r;
  assign tmo_hit_s = (state_r == BURST) && !e_valid && (tmo_r == TMO_W'(TIMEOUT - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: enter BURST on a multi-beat E start, leave on last beat or timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (e_first_s && !e_last) begin
          state_nxt_s = BURST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        if ((e_fire_s && e_last) || tmo_hit_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BURST;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Ready outputs: depend on state, rr pointer and the other side's valid only.
  always_comb begin
    v_ready_s = 1'b0;
    e_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        v_ready_s = !e_valid || favour_v_r;
        e_ready_s = !v_valid || !favour_v_r;
      end
      BURST: begin
        v_ready_s = 1'b0;
        e_ready_s = 1'b1;
      end
      default: begin
        v_ready_s = 1'b0;
        e_ready_s = 1'b0;
      end
    endcase
  end

  assign v_ready = v_ready_s;
  assign e_ready = e_ready_s;

  // Round-robin pointer, burst idle timer and burst target lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      favour_v_r <= 1'b1;
      tmo_r      <= '0;
      lock_reg_r <= '0;
      lock_bad_r <= 1'b0;
    end else begin
      if (v_fire_s) begin
        favour_v_r <= 1'b0;
      end else if (e_fire_s) begin
        favour_v_r <= 1'b1;
      end
      if ((state_r == BURST) && !e_valid && !tmo_hit_s) begin
        tmo_r <= tmo_r + TMO_W'(1);
      end else begin
        tmo_r <= '0;
      end
      if (e_first_s) begin
        lock_reg_r <= e_wd;
        lock_bad_r <= e_bad_s;
      end
    end
  end

  // Regfile write controls, one registered cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r        <= 1'b0;
      err_r       <= 1'b0;
      clr_pend_r  <= 1'b0;
      wd3_r       <= '0;
      isvector_r  <= 1'b0;
      vect_esc_r  <= 1'b0;
      index_a_r   <= '0;
      data_in_r   <= '0;
      data_in_v_r <= '0;
    end else begin
      we_r       <= (v_fire_s && !v_bad_s) || (e_fire_s && !e_bad_s);
      err_r      <= (v_fire_s && v_bad_s) || (e_first_s && e_bad_s) || tmo_hit_s;
      clr_pend_r <= v_fire_s || (e_fire_s && e_last);
      if (v_fire_s) begin
        wd3_r       <= v_wd;
        isvector_r  <= 1'b1;
        vect_esc_r  <= 1'b0;
        data_in_v_r <= v_data;
      end else if (e_fire_s) begin
        wd3_r      <= e_addr_s;
        isvector_r <= 1'b1;
        vect_esc_r <= 1'b1;
        index_a_r  <= e_idx;
        data_in_r  <= e_data;
      end
    end
  end

  assign we        = we_r;
  assign err       = err_r;
  assign wd3       = wd3_r;
  assign isvector  = isvector_r;
  assign vect_esc  = vect_esc_r;
  assign index_A   = index_a_r;
  assign data_in   = data_in_r;
  assign data_in_v = data_in_v_r;

  logic                    sb_set_s, sb_clr_s;
  logic [ADDRESSWIDTH-1:0] sb_set_addr_s, sb_clr_addr_s;

  // Illegal targets never get a pending write, so they never mark busy.
  assign sb_set_s      = (v_fire_s && !v_bad_s) || (e_first_s && !e_bad_s);
  assign sb_set_addr_s = v_fire_s ? v_wd : e_wd;
  assign sb_clr_s      = (we_r && clr_pend_r) || tmo_hit_s;
  assign sb_clr_addr_s = tmo_hit_s ? lock_reg_r : wd3_r;

  vrf_scoreboard #(
    .REGNUM       (REGNUM),
    .ADDRESSWIDTH (ADDRESSWIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (sb_set_s),
    .set_addr (sb_set_addr_s),
    .clr_en   (sb_clr_s),
    .clr_addr (sb_clr_addr_s),
    .busy     (busy)
  );

`ifdef VRF_ARB_STATS_EN
  logic [31:0] stat_v_grants_r, stat_e_beats_r, stat_v_stalls_r;

  // Saturating grant, beat and stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_v_grants_r <= 32'd0;
      stat_e_beats_r  <= 32'd0;
      stat_v_stalls_r <= 32'd0;
    end else begin
      if (v_fire_s && (stat_v_grants_r != 32'hFFFF_FFFF)) begin
        stat_v_grants_r <= stat_v_grants_r + 32'd1;
      end
      if (e_fire_s && (stat_e_beats_r != 32'hFFFF_FFFF)) begin
        stat_e_beats_r <= stat_e_beats_r + 32'd1;
      end
      if (v_valid && !v_ready_s && (stat_v_stalls_r != 32'hFFFF_FFFF)) begin
        stat_v_stalls_r <= stat_v_stalls_r + 32'd1;
      end
    end
  end

  assign stat_v_grants = stat_v_grants_r;
  assign stat_e_beats  = stat_e_beats_r;
  assign stat_v_stalls = stat_v_stalls_r;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Directed self-checking bench for vrf_write_arbiter.
module tb_vrf_write_arbiter;

  localparam int W  = 24;
  localparam int RN = 16;
  localparam int VW = 8;
  localparam int AW = 4;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          v_valid, v_ready;
  logic [AW-1:0] v_wd;
  logic [VW*W-1:0] v_data;
  logic          e_valid, e_ready;
  logic [AW-1:0] e_wd;
  logic [LW-1:0] e_idx;
  logic [W-1:0]  e_data;
  logic          e_last;
  logic          we, isvector, vect_esc, err;
  logic [AW-1:0] wd3;
  logic [LW-1:0] index_A;
  logic [W-1:0]  data_in;
  logic [VW*W-1:0] data_in_v;
  logic [RN-1:0] busy;
`ifdef VRF_ARB_STATS_EN
  logic [31:0]   stat_v_grants, stat_e_beats, stat_v_stalls;
`endif

  int checks = 0;
  int errors = 0;

  vrf_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .v_valid(v_valid), .v_ready(v_ready), .v_wd(v_wd), .v_data(v_data),
    .e_valid(e_valid), .e_ready(e_ready), .e_wd(e_wd), .e_idx(e_idx),
    .e_data(e_data), .e_last(e_last),
    .we(we), .wd3(wd3), .isvector(isvector), .vect_esc(vect_esc),
    .index_A(index_A), .data_in(data_in), .data_in_v(data_in_v),
    .busy(busy), .err(err)
`ifdef VRF_ARB_STATS_EN
    , .stat_v_grants(stat_v_grants), .stat_e_beats(stat_e_beats),
    .stat_v_stalls(stat_v_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v_valid = 1'b0; e_valid = 1'b0; e_last = 1'b0;
    v_wd = '0; v_data = '0; e_wd = '0; e_idx = '0; e_data = '0;
    tick(); tick();
    checks++;
    if ({we, err, wd3, isvector, vect_esc, index_A, data_in} !== '0 || data_in_v !== '0 || busy !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%0b err=%0b wd3=%0h busy=%0h exp all 0", we, err, wd3, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (v_ready !== 1'b1 || e_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got v=%0b e=%0b exp 1 1", v_ready, e_ready);
    end
  endtask

  task automatic test_round_robin();
    int v_left = 4;
    int e_left = 4;
    int stalls = 0;
    logic exp_v;
    v_valid = 1'b1; v_wd = 4'd1; v_data = {VW{24'h000111}};
    e_valid = 1'b1; e_wd = 4'd6; e_idx = 3'd2; e_data = 24'h0000E6; e_last = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_v = (k % 2 == 0);
      checks++;
      if (v_ready !== exp_v || e_ready !== !exp_v) begin
        errors++;
        $display("FAIL rr_grant step %0d got v=%0b e=%0b exp v=%0b", k, v_ready, e_ready, exp_v);
      end
      if (v_valid && !v_ready) stalls++;
      tick();
      checks++;
      if (we !== 1'b1 || wd3 !== (exp_v ? 4'd1 : 4'd6) || vect_esc !== !exp_v) begin
        errors++;
        $display("FAIL rr_write step %0d got we=%0b wd3=%0h esc=%0b exp wd3=%0h", k, we, wd3, vect_esc, exp_v ? 4'd1 : 4'd6);
      end
      if (exp_v) v_left--; else e_left--;
      if (v_left == 0) v_valid = 1'b0;
      if (e_left == 0) e_valid = 1'b0;
    end
    checks++;
    if (stalls != 3) begin
      errors++;
      $display("FAIL rr_stalls got %0d exp 3", stalls);
    end
`ifdef VRF_ARB_STATS_EN
    checks++;
    if (stat_v_stalls !== 32'd3 || stat_v_grants !== 32'd4 || stat_e_beats !== 32'd4) begin
      errors++;
      $display("FAIL rr_stats got stalls=%0d vg=%0d eb=%0d exp 3 4 4", stat_v_stalls, stat_v_grants, stat_e_beats);
    end
`endif
    tick(); tick();
  endtask

  task automatic test_v_only();
    logic [VW*W-1:0] exp_d;
    exp_d = {VW{24'h00A5A5}};
    v_valid = 1'b1; v_wd = 4'd3; v_data = exp_d;
    #1;
    checks++;
    if (v_ready !== 1'b1) begin
      errors++;
      $display("FAIL v_only_ready got %0b exp 1", v_ready);
    end
    tick();
    v_valid = 1'b0;
    checks++;
    if (we !== 1'b1 || wd3 !== 4'd3 || {isvector, vect_esc} !== 2'b10 || data_in_v !== exp_d || busy !== 16'h0008 || err !== 1'b0) begin
      errors++;
      $display("FAIL v_only_write got we=%0b wd3=%0h mode=%0b%0b busy=%0h err=%0b exp 1 3 10 0008 0", we, wd3, isvector, vect_esc, busy, err);
    end
    tick();
    checks++;
    if (we !== 1'b0 || busy !== 16'h0000) begin
      errors++;
      $display("FAIL v_only_after got we=%0b busy=%0h exp 0 0000", we, busy);
    end
  endtask

  task automatic test_e_burst();
    v_valid = 1'b1; v_wd = 4'd2; v_data = {VW{24'h0C0C0C}};
    e_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e_wd = (i == 0) ? 4'd5 : 4'd9;
      e_idx = LW'(i);
      e_data = 24'h100000 + 24'(i);
      e_last = (i == 7);
      #1;
      checks++;
      if (e_ready !== 1'b1 || v_ready !== 1'b0) begin
        errors++;
        $display("FAIL burst_ready beat %0d got e=%0b v=%0b exp 1 0", i, e_ready, v_ready);
      end
      tick();
      checks++;
      if (we !== 1'b1 || wd3 !== 4'd5 || {isvector, vect_esc} !== 2'b11 || index_A !== LW'(i) || data_in !== 24'h100000 + 24'(i) || busy[5] !== 1'b1) begin
        errors++;
        $display("FAIL burst_write beat %0d got we=%0b wd3=%0h idx=%0d data=%0h busy=%0h exp wd3=5 idx=%0d", i, we, wd3, index_A, data_in, busy, i);
      end
    end
    e_valid = 1'b0; e_last = 1'b0;
    #1;
    checks++;
    if (v_ready !== 1'b1) begin
      errors++;
      $display("FAIL burst_v_after got %0b exp 1", v_ready);
    end
    tick();
    v_valid = 1'b0;
    checks++;
    if (we !== 1'b1 || wd3 !== 4'd2 || {isvector, vect_esc} !== 2'b10 || busy !== 16'h0004) begin
      errors++;
      $display("FAIL burst_v_write got we=%0b wd3=%0h busy=%0h exp 1 2 0004", we, wd3, busy);
    end
    tick();
  endtask

  task automatic test_timeout();
    e_valid = 1'b1; e_wd = 4'd7; e_idx = 3'd0; e_data = 24'h00_0077; e_last = 1'b0;
    tick();
    e_valid = 1'b0;
    checks++;
    if (we !== 1'b1 || busy !== 16'h0080) begin
      errors++;
      $display("FAIL tmo_start got we=%0b busy=%0h exp 1 0080", we, busy);
    end
    for (int i = 1; i < 15; i++) begin
      tick();
      checks++;
      if (err !== 1'b0 || v_ready !== 1'b0 || busy !== 16'h0080) begin
        errors++;
        $display("FAIL tmo_wait idle %0d got err=%0b v_ready=%0b busy=%0h exp 0 0 0080", i, err, v_ready, busy);
      end
    end
    tick();
    checks++;
    if (err !== 1'b1 || v_ready !== 1'b1 || busy !== 16'h0000 || we !== 1'b0) begin
      errors++;
      $display("FAIL tmo_abort got err=%0b v_ready=%0b busy=%0h we=%0b exp 1 1 0 0", err, v_ready, busy, we);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_err_pulse got %0b exp 0", err);
    end
  endtask

  task automatic test_illegal();
    v_valid = 1'b1; v_wd = 4'hF; v_data = {VW{24'hBADBAD}};
    #1;
    checks++;
    if (v_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_ready got %0b exp 1", v_ready);
    end
    tick();
    v_valid = 1'b0;
    checks++;
    if (we !== 1'b0 || err !== 1'b1 || busy !== 16'h0000) begin
      errors++;
      $display("FAIL illegal_write got we=%0b err=%0b busy=%0h exp 0 1 0", we, err, busy);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err_pulse got %0b exp 0", err);
    end
  endtask

  task automatic test_reset_mid_burst();
    e_valid = 1'b1; e_wd = 4'd4; e_idx = 3'd0; e_data = 24'h000040; e_last = 1'b0;
    tick();
    e_idx = 3'd1; e_data = 24'h000041;
    tick();
    checks++;
    if (we !== 1'b1 || busy !== 16'h0010) begin
      errors++;
      $display("FAIL midrst_pre got we=%0b busy=%0h exp 1 0010", we, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({we, err, wd3, isvector, vect_esc, index_A, data_in} !== '0 || busy !== '0) begin
      errors++;
      $display("FAIL midrst_async got we=%0b wd3=%0h busy=%0h data=%0h exp all 0", we, wd3, busy, data_in);
    end
    @(negedge clk);
    e_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v_valid = 1'b1; v_wd = 4'd9; v_data = {VW{24'h000999}};
    #1;
    checks++;
    if (v_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_v_ready got %0b exp 1", v_ready);
    end
    tick();
    v_valid = 1'b0;
    checks++;
    if (we !== 1'b1 || wd3 !== 4'd9 || {isvector, vect_esc} !== 2'b10 || busy !== 16'h0200) begin
      errors++;
      $display("FAIL midrst_v_write got we=%0b wd3=%0h busy=%0h exp 1 9 0200", we, wd3, busy);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_v_only();
    test_e_burst();
    test_timeout();
    test_illegal();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
